// File: rtl/a_g_d_c.sv
`default_nettype none
// ============================================================================
// Module   : a_g_d_c
// Purpose  : Automatic garage door controller. A three-state Moore FSM
//            (IDLE / MV_UP / MV_DN) drives the door motor. Activate starts
//            the motion, and the limit switch that is currently asserted
//            sets the direction. The opposite limit switch stops the motor.
// Options  : define AGDC_TIMEOUT_EN to add a run watchdog and a sticky Fault
//            output. The watchdog limit is MAX_RUN_CYCLES and the counter
//            width is CNT_W.
// Revision : 1.0  initial release
// ============================================================================
module a_g_d_c #(
  parameter int MAX_RUN_CYCLES = 1024,
  parameter int CNT_W          = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic Activate,
  input  logic UP_Max,
  input  logic DN_Max,
  output logic UP_M,
`ifdef AGDC_TIMEOUT_EN
  output logic DN_M,
  output logic Fault
`else
  output logic DN_M
`endif
);

  // Elaboration-time sanity check on the watchdog sizing.
  if (MAX_RUN_CYCLES < 2 || MAX_RUN_CYCLES > (1 << 20) ||
      (MAX_RUN_CYCLES >> CNT_W) != 0) begin : g_param_check
    $error("a_g_d_c: MAX_RUN_CYCLES must be 2..2^20 and below 2^CNT_W");
  end

  // IDLE is 00 so the reset state matches the all-zero register value.
  // 2'b11 is unreachable and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MV_UP = 2'b01,
    MV_DN = 2'b10
  } state_t;

  state_t state;
  state_t next_state;
  logic   launch_block;
  logic   timeout;

`ifdef AGDC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

  logic [CNT_W-1:0] run_cnt;
  logic             fault;

  // The limit is reached after MAX_RUN_CYCLES cycles in a moving state.
  assign timeout      = (state == MV_UP || state == MV_DN) && (run_cnt == RUN_LAST);
  assign launch_block = fault;
  assign Fault        = fault;

  // The run counter clears on entry to a moving state and is held at zero
  // while the FSM is idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_cnt <= '0;
    end else if ((state == MV_UP || state == MV_DN) && next_state == state) begin
      run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

  // The fault flag is sticky. Only reset clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fault <= 1'b0;
    end else if (timeout) begin
      fault <= 1'b1;
    end
  end
`else
  assign timeout      = 1'b0;
  assign launch_block = 1'b0;
`endif

  // State register. Asynchronous reset stops the motor immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A launch needs exactly one limit switch set, and the
  // motion ends only when the limit for the current direction is reached.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (Activate && !launch_block) begin
          if (UP_Max && !DN_Max) begin
            next_state = MV_DN;
          end else if (DN_Max && !UP_Max) begin
            next_state = MV_UP;
          end
        end
      end
      MV_UP:   next_state = UP_Max ? IDLE : MV_UP;
      MV_DN:   next_state = DN_Max ? IDLE : MV_DN;
      default: next_state = IDLE;
    endcase
    if (timeout) begin
      next_state = IDLE;
    end
  end

  // Moore output decode of the registered state.
  assign UP_M = (state == MV_UP);
  assign DN_M = (state == MV_DN);

endmodule
`default_nettype wire

// File: tb/tb_a_g_d_c.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_g_d_c
// Purpose  : Directed, self-checking bench for the garage door controller.
//            The timeout scenario runs only when AGDC_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_a_g_d_c;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Activate = 1'b0;
  logic UP_Max = 1'b0;
  logic DN_Max = 1'b0;
  logic UP_M;
  logic DN_M;
`ifdef AGDC_TIMEOUT_EN
  logic Fault;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

`ifdef AGDC_TIMEOUT_EN
  a_g_d_c #(.MAX_RUN_CYCLES(8), .CNT_W(20)) dut (
    .CLK(CLK), .RST(RST), .Activate(Activate), .UP_Max(UP_Max),
    .DN_Max(DN_Max), .UP_M(UP_M), .DN_M(DN_M), .Fault(Fault)
  );
`else
  a_g_d_c dut (
    .CLK(CLK), .RST(RST), .Activate(Activate), .UP_Max(UP_Max),
    .DN_Max(DN_Max), .UP_M(UP_M), .DN_M(DN_M)
  );
`endif

  // Move to 1 ns after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic a, input logic up, input logic dn);
    Activate = a;
    UP_Max   = up;
    DN_Max   = dn;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL reset_held: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
    RST = 1'b1;
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
  endtask

  task automatic test_move_down();
    drive(1'b1, 1'b1, 1'b0);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b01) begin
      fails++;
      $display("FAIL down_launch: {UP_M,DN_M}=%b required 01", {UP_M, DN_M});
    end
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({UP_M, DN_M} !== 2'b01) begin
        fails++;
        $display("FAIL down_travel[%0d]: {UP_M,DN_M}=%b required 01", i, {UP_M, DN_M});
      end
    end
    // Both limits high: the down limit ends the down motion.
    drive(1'b1, 1'b1, 1'b1);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL down_stop: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
    drive(1'b0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_move_up();
    drive(1'b1, 1'b0, 1'b1);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b10) begin
      fails++;
      $display("FAIL up_launch: {UP_M,DN_M}=%b required 10", {UP_M, DN_M});
    end
    drive(1'b0, 1'b0, 1'b1);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b10) begin
      fails++;
      $display("FAIL up_hold_dnmax: {UP_M,DN_M}=%b required 10", {UP_M, DN_M});
    end
    drive(1'b0, 1'b1, 1'b0);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL up_stop: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
  endtask

  task automatic test_back_to_back();
    // Activate is held high. The controller relaunches as soon as one limit is set.
    drive(1'b1, 1'b0, 1'b1);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_up: {UP_M,DN_M}=%b required 10", {UP_M, DN_M});
    end
    drive(1'b1, 1'b1, 1'b0);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_top: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_relaunch_dn: {UP_M,DN_M}=%b required 01", {UP_M, DN_M});
    end
    drive(1'b0, 1'b0, 1'b1);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_bottom: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
  endtask

  task automatic test_idle_hold();
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({UP_M, DN_M} !== 2'b00) begin
        fails++;
        $display("FAIL idle_both_limits[%0d]: {UP_M,DN_M}=%b required 00", i, {UP_M, DN_M});
      end
    end
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({UP_M, DN_M} !== 2'b00) begin
        fails++;
        $display("FAIL idle_no_limit[%0d]: {UP_M,DN_M}=%b required 00", i, {UP_M, DN_M});
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_activate: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (DN_M !== 1'b1) begin
      fails++;
      $display("FAIL arst_launch: DN_M=%b required 1", DN_M);
    end
    #3;
    RST = 1'b0;
    #1;
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL arst_immediate: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
    #2;
    RST = 1'b1;
    step();
    tests++;
    if ({UP_M, DN_M} !== 2'b00) begin
      fails++;
      $display("FAIL arst_release: {UP_M,DN_M}=%b required 00", {UP_M, DN_M});
    end
  endtask

`ifdef AGDC_TIMEOUT_EN
  task automatic test_timeout();
    drive(1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    // Eight cycles with UP_M high, counting the launch cycle.
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({UP_M, DN_M, Fault} !== 3'b100) begin
        fails++;
        $display("FAIL timeout_run[%0d]: {UP_M,DN_M,Fault}=%b required 100", i, {UP_M, DN_M, Fault});
      end
      step();
    end
    tests++;
    if ({UP_M, DN_M, Fault} !== 3'b001) begin
      fails++;
      $display("FAIL timeout_trip: {UP_M,DN_M,Fault}=%b required 001", {UP_M, DN_M, Fault});
    end
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({UP_M, DN_M, Fault} !== 3'b001) begin
        fails++;
        $display("FAIL timeout_lockout[%0d]: {UP_M,DN_M,Fault}=%b required 001", i, {UP_M, DN_M, Fault});
      end
    end
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    tests++;
    if (Fault !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: Fault=%b required 0", Fault);
    end
    step();
    RST = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_move_down();
    test_move_up();
    test_back_to_back();
    test_idle_hold();
    test_async_reset();
`ifdef AGDC_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
